// File: rtl/mem_pkg.sv
// Shared memory-system definitions: line/word geometry and bridge state encoding.
package mem_pkg;

   localparam int LINE_BITS = 256;
   localparam int WORD_BITS = 32;
   localparam int BEATS     = LINE_BITS / WORD_BITS;
   localparam int BEAT_W    = $clog2(BEATS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_ACK     = 3'd3,
      ST_RELEASE = 3'd4
   } bridge_state_e;

endpackage

// File: rtl/line_buf.sv
// Line-wide storage with whole-line load and word-indexed read/write by beat.
module line_buf #(
   parameter int LINE_BITS = mem_pkg::LINE_BITS,
   parameter int WORD_BITS = mem_pkg::WORD_BITS,
   localparam int NWORDS   = LINE_BITS / WORD_BITS,
   localparam int IDX_W    = $clog2(NWORDS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [LINE_BITS-1:0] line_in,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     idx,
   input  logic [WORD_BITS-1:0] word_in,
   output logic [WORD_BITS-1:0] word_out,
   output logic [LINE_BITS-1:0] line_out
);

   logic [NWORDS-1:0][WORD_BITS-1:0] mem;

   // Whole-line load wins over a single-word update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '0;
      end else if (load) begin
         mem <= line_in;
      end else if (wr_en) begin
         mem[idx] <= word_in;
      end
   end

   assign word_out = mem[idx];
   assign line_out = mem;

endmodule

// File: rtl/line_mem_bridge.sv
// Bridges cache-line requests onto a word-wide RAM, one beat per RAM ack.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   IDLE       | waiting for a request; write wins over read
//   READ       | ram_rd_o held, one word stored into data_o per ack
//   WRITE      | ram_we_o held, one latched word presented per ack
//   ACK        | one-cycle ack_o completion pulse
//   RELEASE    | requester still asserting rd_i/we_i; wait for both low
module line_mem_bridge #(
   parameter int LINE_BITS = mem_pkg::LINE_BITS,
   parameter int WORD_BITS = mem_pkg::WORD_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          addr_i,
   input  logic [LINE_BITS-1:0] data_i,
   output logic [LINE_BITS-1:0] data_o,
   input  logic                 rd_i,
   input  logic                 we_i,
   output logic                 ack_o,
   output logic [31:0]          ram_addr_o,
   output logic [WORD_BITS-1:0] ram_data_o,
   input  logic [WORD_BITS-1:0] ram_data_i,
   output logic                 ram_rd_o,
   output logic                 ram_we_o,
   input  logic                 ram_ack_i
);

   import mem_pkg::*;

   localparam int NBEATS = LINE_BITS / WORD_BITS;
   localparam int BW     = $clog2(NBEATS);
   localparam int WO     = $clog2(WORD_BITS / 8);
   localparam int LO     = BW + WO;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   bridge_state_e       state, state_nxt;
   logic [BW-1:0]       beat, beat_nxt;
   logic [31-LO:0]      line_addr, line_addr_nxt;
   logic                wr_load;
   logic                rd_word_we;
   logic [WORD_BITS-1:0] wr_word;
   logic [WORD_BITS-1:0] unused_rd_word;
   logic [LINE_BITS-1:0] unused_wr_line;
   logic                unused_addr_lsb;

   // Byte offset within the line is irrelevant; beats always start at word 0.
   assign unused_addr_lsb = ^addr_i[LO-1:0];

   // State, beat counter and latched line address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         beat      <= '0;
         line_addr <= '0;
      end else begin
         state     <= state_nxt;
         beat      <= beat_nxt;
         line_addr <= line_addr_nxt;
      end
   end

   // Next-state, beat advance and strobe/ack decode.
   always_comb begin
      state_nxt     = state;
      beat_nxt      = beat;
      line_addr_nxt = line_addr;
      wr_load       = 1'b0;
      rd_word_we    = 1'b0;
      ack_o         = 1'b0;
      ram_rd_o      = 1'b0;
      ram_we_o      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (we_i) begin
               state_nxt     = ST_WRITE;
               line_addr_nxt = addr_i[31:LO];
               beat_nxt      = '0;
               wr_load       = 1'b1;
            end else if (rd_i) begin
               state_nxt     = ST_READ;
               line_addr_nxt = addr_i[31:LO];
               beat_nxt      = '0;
            end
         end
         ST_READ: begin
            ram_rd_o = 1'b1;
            if (ram_ack_i) begin
               rd_word_we = 1'b1;
               beat_nxt   = beat + 1'b1;
               if (beat == LAST_BEAT) state_nxt = ST_ACK;
            end
         end
         ST_WRITE: begin
            ram_we_o = 1'b1;
            if (ram_ack_i) begin
               beat_nxt = beat + 1'b1;
               if (beat == LAST_BEAT) state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            ack_o     = 1'b1;
            state_nxt = (rd_i || we_i) ? ST_RELEASE : ST_IDLE;
         end
         ST_RELEASE: begin
            if (!rd_i && !we_i) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign ram_addr_o = {line_addr, beat, {WO{1'b0}}};
   assign ram_data_o = ram_we_o ? wr_word : '0;

   // Read-assembly buffer; its contents are data_o and survive writes.
   line_buf #(.LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS)) u_rd_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .line_in  ('0),
      .wr_en    (rd_word_we),
      .idx      (beat),
      .word_in  (ram_data_i),
      .word_out (unused_rd_word),
      .line_out (data_o)
   );

   // Write-line latch, captured on acceptance so later data_i changes are harmless.
   line_buf #(.LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS)) u_wr_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_load),
      .line_in  (data_i),
      .wr_en    (1'b0),
      .idx      (beat),
      .word_in  ('0),
      .word_out (wr_word),
      .line_out (unused_wr_line)
   );

endmodule

// File: tb/tb_line_mem_bridge.sv
// Randomized scoreboard bench for line_mem_bridge.
module tb_line_mem_bridge;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [255:0] data_i = '0;
   logic [255:0] data_o;
   logic         rd_i = 1'b0;
   logic         we_i = 1'b0;
   logic         ack_o;
   logic [31:0]  ram_addr_o;
   logic [31:0]  ram_data_o;
   logic [31:0]  ram_data_i;
   logic         ram_rd_o;
   logic         ram_we_o;
   logic         ram_ack_i = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } beat_t;

   beat_t        exp_beats[$];
   logic [255:0] exp_lines[$];
   logic [255:0] last_rd_line = '0;
   logic [31:0]  rd_base = '0;
   int           ack_mode = 0;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   // RAM read word k of any line is rd_base + k.
   assign ram_data_i = rd_base + {29'd0, ram_addr_o[4:2]};

   line_mem_bridge dut (
      .clk        (clk),
      .rst        (rst),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .rd_i       (rd_i),
      .we_i       (we_i),
      .ack_o      (ack_o),
      .ram_addr_o (ram_addr_o),
      .ram_data_o (ram_data_o),
      .ram_data_i (ram_data_i),
      .ram_rd_o   (ram_rd_o),
      .ram_we_o   (ram_we_o),
      .ram_ack_i  (ram_ack_i)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RAM ack generator: 0 = always, 1 = every third cycle, 2 = random.
   initial begin
      int cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (ack_mode)
            0:       ram_ack_i = 1'b1;
            1:       ram_ack_i = (cyc % 3 == 0);
            default: ram_ack_i = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor: pops expected beats on each RAM handshake and expected lines on ack_o.
   initial begin
      beat_t        b;
      logic [255:0] l;
      forever begin
         @(negedge clk);
         if (rst && ram_rd_o && ram_we_o) chk("both_strobes", 1, 0);
         if (rst && (ram_rd_o || ram_we_o) && ram_ack_i) begin
            if (exp_beats.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: addr %h rd %b we %b", ram_addr_o, ram_rd_o, ram_we_o);
            end else begin
               b = exp_beats.pop_front();
               chk("beat_addr", ram_addr_o, b.addr);
               chk("beat_we", ram_we_o, b.we);
               chk("beat_rd", ram_rd_o, !b.we);
               if (b.we) chk("beat_wdata", ram_data_o, b.data);
            end
         end
         if (ack_o) begin
            if (exp_lines.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack: data_o %h", data_o);
            end else begin
               l = exp_lines.pop_front();
               chk("ack_data_o", data_o, l);
            end
         end
      end
   end

   task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [255:0] d, input int hold, input bit junk,
                          output int lat);
      beat_t b;
      int    n;
      for (int k = 0; k < 8; k++) begin
         b.addr = {a[31:5], 3'(k), 2'b00};
         b.we   = wr;
         b.data = wr ? d[32*k +: 32] : 32'h0;
         exp_beats.push_back(b);
         if (!wr) last_rd_line[32*k +: 32] = rd_base + 32'(k);
      end
      exp_lines.push_back(last_rd_line);
      @(negedge clk);
      we_i   = wr;
      rd_i   = rd;
      addr_i = a;
      data_i = d;
      @(negedge clk);
      n = 1;
      if (junk) begin
         rd_i   = 1'($urandom);
         we_i   = 1'($urandom);
         addr_i = $urandom;
         for (int w = 0; w < 8; w++) data_i[32*w +: 32] = $urandom;
      end else begin
         rd_i = 1'b0;
         we_i = 1'b0;
      end
      while (!ack_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      if (!ack_o) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout: no ack_o after %0d cycles, required within 400", n);
      end
      chk("beats_done_at_ack", exp_beats.size(), 0);
      rd_i = (hold > 0);
      we_i = 1'b0;
      @(negedge clk);
      chk("ack_single", ack_o, 0);
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         chk("release_quiet", {ack_o, ram_rd_o, ram_we_o}, 0);
      end
      rd_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, ack_o, 0);
      chk({tag, "_rd"}, ram_rd_o, 0);
      chk({tag, "_we"}, ram_we_o, 0);
      chk({tag, "_addr"}, ram_addr_o, 0);
      chk({tag, "_wdata"}, ram_data_o, 0);
      chk({tag, "_data_o"}, data_o, 0);
   endtask

   initial begin
      int           lat;
      logic [255:0] d;
      logic [31:0]  a;
      beat_t        b;
      bit           wr, rd;

      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;

      // Zero-wait read of line 0x1220.
      ack_mode = 0;
      rd_base  = 32'hA000_0000;
      run_txn(0, 1, 32'h0000_1234, '0, 0, 0, lat);
      chk("read_latency", lat, 9);
      chk("read_word0", data_o[31:0], 32'hA000_0000);
      chk("read_word7", data_o[255:224], 32'hA000_0007);

      // Wait-state write, words 0..7.
      ack_mode = 1;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'(k);
      run_txn(1, 0, 32'h0004_5660, d, 0, 0, lat);
      chk("write_keeps_data_o", data_o[31:0], 32'hA000_0000);

      // Simultaneous read and write requests: write wins.
      ack_mode = 0;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      run_txn(1, 1, 32'h8000_00A0, d, 0, 0, lat);
      chk("write_latency", lat, 9);

      // Requester holds rd_i three cycles past ack_o.
      rd_base = 32'h1357_0000;
      run_txn(0, 1, 32'h0000_2000, '0, 3, 0, lat);
      rd_base = 32'h2468_0000;
      run_txn(0, 1, 32'h0000_3000, '0, 0, 0, lat);

      // Reset pulse during a read at beat 4.
      rd_base = 32'h5555_0000;
      for (int k = 0; k < 8; k++) begin
         b.addr = {27'h7FF_FFFF, 3'(k), 2'b00};
         b.we   = 1'b0;
         b.data = 32'h0;
         exp_beats.push_back(b);
      end
      @(negedge clk);
      rd_i   = 1'b1;
      addr_i = 32'hFFFF_FFE0;
      @(negedge clk);
      rd_i = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs("midread_reset");
      chk("beats_before_reset", exp_beats.size(), 3);
      exp_beats.delete();
      last_rd_line = '0;
      #1 rst = 1'b1;
      rd_base = 32'h9ABC_0000;
      run_txn(0, 1, 32'h0000_4440, '0, 0, 0, lat);
      chk("post_reset_word7", data_o[255:224], 32'h9ABC_0007);

      // Randomized mix with wait states and input churn during transfers.
      ack_mode = 2;
      for (int t = 0; t < 24; t++) begin
         rd_base = $urandom;
         a       = $urandom;
         for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
         wr = 1'($urandom);
         rd = wr ? 1'($urandom) : 1'b1;
         run_txn(wr, rd, a, d, $urandom_range(0, 3), 1, lat);
      end

      repeat (4) @(negedge clk);
      chk("leftover_beats", exp_beats.size(), 0);
      chk("leftover_lines", exp_lines.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
